// File: rtl/div_share_sched_if.sv
// rtl/div_share_sched_if.sv - request, response and divider handshake bundle for div_share_sched
interface div_share_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [WIDTH-1:0]         resp_quotient;
  logic [WIDTH-1:0]         resp_remainder;
  logic                     resp_dbz;
  logic                     div_start;
  logic [WIDTH-1:0]         div_dividend;
  logic [WIDTH-1:0]         div_divisor;
  logic [WIDTH-1:0]         div_quotient;
  logic [WIDTH-1:0]         div_remainder;
  logic                     div_ready;
  logic                     busy;

  modport master (
    input  req_valid, req_dividend, req_divisor, resp_ready,
           div_quotient, div_remainder, div_ready,
    output req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
           resp_dbz, div_start, div_dividend, div_divisor, busy
  );

  modport slave (
    output req_valid, req_dividend, req_divisor, resp_ready,
           div_quotient, div_remainder, div_ready,
    input  req_ready, resp_valid, resp_id, resp_quotient, resp_remainder,
           resp_dbz, div_start, div_dividend, div_divisor, busy
  );
endinterface

// File: rtl/div_share_sched.sv
// rtl/div_share_sched.sv - round-robin scheduler sharing one start/ready divider among NUM_REQ requesters
// Optional divider watchdog and sticky timeout_err port: define DIVSCHED_TIMEOUT_EN.
module div_share_sched #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  div_share_sched_if.master bus
`ifdef DIVSCHED_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [WIDTH-1:0] r_div_dividend;
  logic [WIDTH-1:0] r_div_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_div_start;
  logic             r_resp_valid;
  logic             r_dbz;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic               w_grant_any;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sel_dividend;
  logic [WIDTH-1:0]   w_sel_divisor;
  int                 w_idx;

`ifdef DIVSCHED_TIMEOUT_EN
  // Last WAIT count before giving up; resp_valid then rises WIDTH+8 edges after the start pulse.
  localparam int TO_LIMIT = WIDTH + 6;
  localparam int WD_W     = $clog2(WIDTH + 8) + 1;
  logic [WD_W-1:0] r_wdog;
  logic            r_timeout_err;
  assign timeout_err = r_timeout_err;
`endif

  // Search starts just after the last granted requester and wraps to 0.
  always_comb begin
    w_grant     = '0;
    w_grant_id  = '0;
    w_grant_any = 1'b0;
    w_idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_grant_any && bus.req_valid[w_idx]) begin
        w_grant_any    = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_grant_id     = ID_W'(w_idx);
      end
    end
  end

  assign w_accept       = w_grant_any && (r_state == IDLE);
  assign w_sel_dividend = bus.req_dividend[w_grant_id*WIDTH +: WIDTH];
  assign w_sel_divisor  = bus.req_divisor[w_grant_id*WIDTH +: WIDTH];

  assign bus.req_ready      = (reset_n && r_state == IDLE) ? w_grant : '0;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_id        = r_id;
  assign bus.resp_quotient  = r_quot;
  assign bus.resp_remainder = r_rem;
  assign bus.resp_dbz       = r_dbz;
  assign bus.div_start      = r_div_start;
  assign bus.div_dividend   = r_div_dividend;
  assign bus.div_divisor    = r_div_divisor;
  assign bus.busy           = (r_state != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_rr_ptr       <= ID_W'(NUM_REQ - 1);
      r_id           <= '0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_quot         <= '0;
      r_rem          <= '0;
      r_div_start    <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_dbz          <= 1'b0;
`ifdef DIVSCHED_TIMEOUT_EN
      r_wdog         <= '0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_id     <= w_grant_id;
            r_rr_ptr <= w_grant_id;
            if (w_sel_divisor == '0) begin
              // Divider is never touched; resp_valid follows one cycle later from RESP.
              r_quot  <= '1;
              r_rem   <= w_sel_dividend;
              r_dbz   <= 1'b1;
              r_state <= RESP;
            end else begin
              r_div_dividend <= w_sel_dividend;
              r_div_divisor  <= w_sel_divisor;
              r_div_start    <= 1'b1;
              r_state        <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_div_start <= 1'b0;
`ifdef DIVSCHED_TIMEOUT_EN
          r_wdog      <= '0;
`endif
          r_state     <= WAIT;
        end
        WAIT: begin
          if (bus.div_ready) begin
            r_quot       <= bus.div_quotient;
            r_rem        <= bus.div_remainder;
            r_dbz        <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
`ifdef DIVSCHED_TIMEOUT_EN
          else if (r_wdog == WD_W'(TO_LIMIT)) begin
            r_quot        <= '1;
            r_rem         <= '0;
            r_dbz         <= 1'b1;
            r_resp_valid  <= 1'b1;
            r_timeout_err <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        RESP: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_sched.sv
// tb/tb_div_share_sched.sv - randomized self-checking bench for div_share_sched with a reference model
module tb_div_share_sched;
  localparam int NUM_REQ = 3;
  localparam int WIDTH   = 16;
  localparam int ID_W    = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  div_share_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) bus ();

`ifdef DIVSCHED_TIMEOUT_EN
  logic timeout_err;
`endif

  div_share_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef DIVSCHED_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Divider stand-in: no reset, ready pulses WIDTH+1 edges after it samples start.
  logic div_dead = 1'b0;
  int   dcnt = 0;
  always @(posedge clock) begin
    bus.div_ready <= 1'b0;
    if (bus.div_start) begin
      dcnt              <= WIDTH + 1;
      bus.div_quotient  <= bus.div_dividend / bus.div_divisor;
      bus.div_remainder <= bus.div_dividend % bus.div_divisor;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !div_dead) bus.div_ready <= 1'b1;
    end
  end

  typedef struct {
    int               id;
    logic [WIDTH-1:0] dvd, dvs, q, r;
    bit               dbz;
    int               acc;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  int   ids_seen[$];
  int   cyc = 0;
  int   last_gid = NUM_REQ - 1;
  int   hs_cyc = -10;
  int   starts = 0, exp_starts = 0;
  bit   prev_hold = 0, prev_start = 0;
  logic [NUM_REQ-1:0] acc_mask_last = '0;
  logic [ID_W-1:0]  prev_id;
  logic [WIDTH-1:0] prev_q, prev_r;
  logic             prev_dbz;
  logic [WIDTH-1:0] hs_q, hs_r;
  int               hs_id;
  bit               hs_dbz;
  int   m_id;
  exp_t m_e;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      acc_mask_last = '0;
    end else begin
      acc_mask_last = bus.req_valid & bus.req_ready;
      check("rdy_onehot", ($countones(bus.req_ready) <= 1), 1);
      if (bus.busy) check("rdy_while_busy", bus.req_ready, 0);
      if (acc_mask_last != '0) begin
        m_id = 0;
        for (int i = 0; i < NUM_REQ; i++) if (acc_mask_last[i]) m_id = i;
        check("rr_grant", m_id, rr_pick(bus.req_valid, last_gid));
        check("acc_after_hs", (cyc + 1 > hs_cyc), 1);
        last_gid = m_id;
        m_e.id  = m_id;
        m_e.dvd = bus.req_dividend[m_id*WIDTH +: WIDTH];
        m_e.dvs = bus.req_divisor[m_id*WIDTH +: WIDTH];
        m_e.acc = cyc + 1;
        if (m_e.dvs == 0) begin
          m_e.q = '1; m_e.r = m_e.dvd; m_e.dbz = 1; m_e.lat = 1;
        end else if (div_dead) begin
          m_e.q = '1; m_e.r = '0; m_e.dbz = 1; m_e.lat = WIDTH + 8;
          exp_starts++;
        end else begin
          m_e.q = m_e.dvd / m_e.dvs; m_e.r = m_e.dvd % m_e.dvs; m_e.dbz = 0; m_e.lat = WIDTH + 3;
          exp_starts++;
        end
        exp_q.push_back(m_e);
      end
      if (bus.div_start) begin
        starts++;
        check("start_one_cycle", prev_start, 0);
        if (exp_q.size() > 0)
          check("launch_ops", {bus.div_dividend, bus.div_divisor}, {exp_q[$].dvd, exp_q[$].dvs});
      end
      prev_start = bus.div_start;
      if (bus.resp_valid) begin
        if (!prev_hold) begin
          if (exp_q.size() == 0) check("spurious_resp", 1, 0);
          else begin
            check("resp_latency", cyc - exp_q[0].acc, exp_q[0].lat);
            check("resp_id", bus.resp_id, exp_q[0].id);
            check("resp_q", bus.resp_quotient, exp_q[0].q);
            check("resp_r", bus.resp_remainder, exp_q[0].r);
            check("resp_dbz", bus.resp_dbz, exp_q[0].dbz);
          end
        end else begin
          check("resp_stable", {bus.resp_id, bus.resp_quotient, bus.resp_remainder, bus.resp_dbz},
                {prev_id, prev_q, prev_r, prev_dbz});
        end
        if (bus.resp_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs_cyc = cyc + 1;
          hs_id = int'(bus.resp_id); hs_q = bus.resp_quotient; hs_r = bus.resp_remainder; hs_dbz = bus.resp_dbz;
          ids_seen.push_back(int'(bus.resp_id));
        end
      end
      prev_hold = bus.resp_valid && !bus.resp_ready;
      prev_id = bus.resp_id; prev_q = bus.resp_quotient; prev_r = bus.resp_remainder; prev_dbz = bus.resp_dbz;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, bus.req_ready, 0);
    check({tag, "_resp"}, {bus.resp_valid, bus.resp_id, bus.resp_quotient, bus.resp_remainder, bus.resp_dbz}, 0);
    check({tag, "_div"}, {bus.div_start, bus.div_dividend, bus.div_divisor}, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset_n   = 1'b0;
    exp_q     = {};
    last_gid  = NUM_REQ - 1;
    prev_hold = 0;
    prev_start = 0;
    bus.req_valid = '0; bus.req_valid[1] = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_reset_outputs("reset");
    end
    @(posedge clock); #1;
    bus.req_valid = '0;
    reset_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_dividend[i*WIDTH +: WIDTH] = a;
    bus.req_divisor[i*WIDTH +: WIDTH]  = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    @(posedge clock); #1;
    set_op(i, a, b);
    n = 0;
    do begin
      @(negedge clock); n++;
    end while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 200);
    check("issue_accepted", (n < 200), 1);
    @(posedge clock); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      @(negedge clock); n++;
    end
    check("drain_done", (exp_q.size() == 0 && !bus.busy), 1);
  endtask

  initial begin
    int n, nacc;
    bus.req_valid = '0; bus.req_dividend = '0; bus.req_divisor = '0; bus.resp_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_outputs("por");
    @(posedge clock); #1 reset_n = 1'b1;

    // Two requesters held valid: grants must alternate starting at 0.
    ids_seen = {};
    @(posedge clock); #1;
    set_op(0, 16'd51000, 16'd255);
    set_op(1, 16'd100, 16'd3);
    nacc = 0; n = 0;
    while (nacc < 6 && n < 400) begin
      @(negedge clock); n++;
      if (acc_mask_last != '0) nacc++;
      @(posedge clock); #1;
    end
    bus.req_valid = '0;
    drain(100);
    check("rr_count", ids_seen.size(), 6);
    for (int k = 0; k < 6 && k < ids_seen.size(); k++) check("rr_seq", ids_seen[k], k % 2);
    check("rr_last", {hs_q, hs_r}, {16'd33, 16'd1});

    issue(0, 16'd1000, 16'd7);
    drain(100);
    check("t_1000_7", {hs_id[3:0], hs_q, hs_r, hs_dbz}, {4'd0, 16'd142, 16'd6, 1'b0});

    issue(1, 16'h1234, 16'd0);
    drain(50);
    check("t_dbz", {hs_id[3:0], hs_q, hs_r, hs_dbz}, {4'd1, 16'hFFFF, 16'h1234, 1'b1});

    // Stalled response with another requester waiting.
    bus.resp_ready = 1'b0;
    issue(2, 16'd50, 16'd5);
    bus.req_valid[0] = 1'b1;
    n = 0;
    while (!bus.resp_valid && n < 100) begin @(negedge clock); n++; end
    check("stall_resp_seen", bus.resp_valid, 1);
    repeat (10) begin
      @(negedge clock);
      check("stall_fields", {bus.resp_valid, bus.resp_quotient, bus.resp_remainder, bus.req_ready},
            {1'b1, 16'd10, 16'd0, 3'b000});
    end
    @(posedge clock); #1 bus.resp_ready = 1'b1;
    n = 0;
    while (acc_mask_last == '0 && n < 20) begin @(negedge clock); n++; end
    @(posedge clock); #1 bus.req_valid = '0;
    drain(100);

    // Reset while the divider is busy; the late completion must be ignored.
    issue(0, 16'd300, 16'd7);
    repeat (5) @(negedge clock);
    check("in_wait_busy", bus.busy, 1);
    apply_reset();
    repeat (30) @(negedge clock);
    issue(1, 16'd9, 16'd2);
    drain(100);
    check("t_after_reset", {hs_id[3:0], hs_q, hs_r, hs_dbz}, {4'd1, 16'd4, 16'd1, 1'b0});

`ifdef DIVSCHED_TIMEOUT_EN
    div_dead = 1'b1;
    check("to_err_clear", timeout_err, 0);
    issue(2, 16'd77, 16'd3);
    drain(100);
    check("t_timeout", {hs_q, hs_r, hs_dbz}, {16'hFFFF, 16'h0, 1'b1});
    repeat (5) begin
      @(negedge clock);
      check("to_err_sticky", timeout_err, 1);
    end
    div_dead = 1'b0;
    apply_reset();
    @(negedge clock);
    check("to_err_reset", timeout_err, 0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask_last[i]) begin
          if ($urandom_range(1) == 0) bus.req_valid[i] = 1'b0;
          else set_op(i, WIDTH'($urandom), ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom >> $urandom_range(31, 16)));
        end else if (!bus.req_valid[i] && $urandom_range(9) < 3) begin
          set_op(i, WIDTH'($urandom), ($urandom_range(7) == 0) ? '0 : WIDTH'($urandom >> $urandom_range(31, 16)));
        end
      end
      bus.resp_ready = ($urandom_range(9) < 7);
    end
    @(posedge clock); #1;
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    drain(200);
    check("start_count", starts, exp_starts);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Round-robin scheduler that shares one iterative restoring divider instance (`divider`, start/ready interface) between NUM_REQ requesters.
- Typical requesters are the HSV pipeline's saturation and hue quotients, plus later colour-tracking stages.
- Accepts one request at a time, drives the divider, and returns the quotient and remainder tagged with the requester ID.
- Divide-by-zero requests bypass the divider.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 16, operand/result width; must match the divider instance's WIDTH.
- ID_W, 3, width of resp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_dividend  in  NUM_REQ*WIDTH  flattened dividends; requester i occupies bits [i*WIDTH +: WIDTH].
- req_divisor  in  NUM_REQ*WIDTH  flattened divisors, same packing.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  index of the requester the response belongs to.
- resp_quotient  out  WIDTH  quotient.
- resp_remainder  out  WIDTH  remainder.
- resp_dbz  out  1  divide-by-zero flag.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  WIDTH  divider dividend; registered, stable from launch to completion.
- div_divisor  out  WIDTH  divider divisor; registered, stable from launch to completion.
- div_quotient  in  WIDTH  divider quotient.
- div_remainder  in  WIDTH  divider remainder.
- div_ready  in  1  divider completion pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=NUM_REQ-1.
  - All outputs 0: resp_*, div_start, div_dividend, div_divisor, busy.
  - req_ready=0 while reset_n=0.
- Divider has no reset. After reset the block ignores div_ready in IDLE. A new div_start reloads the divider, so a stale completion can never be mistaken for a new result.
- States: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE. Divide-by-zero path: IDLE -> RESP.
- Arbitration (IDLE only):
  - Combinational grant to the first requester with req_valid=1, searching from rr_ptr+1 upward with wrap to 0.
  - req_ready = grant bit while state==IDLE, else 0.
  - Accept = req_valid[i] & req_ready[i] at a rising edge. On accept: latch operands and id, set rr_ptr=i.
- Round-robin fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other transactions.
- Divide by zero (divisor==0 on accept):
  - Go directly to RESP with resp_quotient = all ones, resp_remainder = dividend, resp_dbz=1.
  - resp_valid rises 1 cycle after the accepting edge.
- LAUNCH: div_start=1 for exactly one cycle; div_dividend/div_divisor already hold the latched operands.
- WAIT:
  - Hold operands. On the cycle div_ready is sampled high, capture div_quotient/div_remainder into resp_*, set resp_dbz=0, go to RESP.
  - The block must wait on div_ready, not count cycles.
  - With the team divider, resp_valid rises WIDTH+3 cycles after the accepting edge.
- RESP:
  - resp_valid=1; resp_id, resp_quotient, resp_remainder and resp_dbz held stable until resp_valid & resp_ready.
  - After that handshake, resp_valid=0 and state=IDLE the next cycle.
  - A new request can be accepted no earlier than the cycle after the response handshake.
  - If resp_ready is already high when resp_valid rises, the handshake completes in that cycle.
- div_ready seen outside WAIT: ignored.
- req_valid deasserted by a requester after accept: no effect; the transaction completes and is delivered.
- Reset asserted mid-transaction: transaction dropped with no response; the requester must reissue.

Optional Feature:
- Macro: DIVSCHED_TIMEOUT_EN.
- When defined:
  - WAIT has a watchdog counter cleared on LAUNCH.
  - If div_ready has not been seen within WIDTH+8 cycles of div_start, go to RESP with resp_quotient=all ones, resp_remainder=0, resp_dbz=1.
  - Sticky output timeout_err (1 bit, cleared only by reset) goes high.
- When undefined: no counter, no timeout_err port, and WAIT lasts indefinitely.

Test Plan:
- Single request, requester 0, 1000/7, WIDTH=16, resp_ready=1 -> quotient 142, remainder 6, resp_id=0, resp_dbz=0, resp_valid exactly WIDTH+3 cycles after accept, div_start high one cycle.
- Both requesters valid continuously, operands 255*200/255 and 100/3, for 6 transactions -> grants alternate 0,1,0,1,0,1 with correct results 200 r0 and 33 r1.
- Divisor 0, dividend 0x1234 from requester 1 -> resp_valid 1 cycle after accept, quotient 0xFFFF, remainder 0x1234, resp_dbz=1, div_start never asserted.
- resp_ready held low 10 cycles on a completed 50/5 -> resp_valid and resp fields stable at 10 r0 throughout, req_ready all 0, no second accept until the cycle after the handshake.
- reset_n pulsed low during WAIT, then new request 9/2 -> all outputs 0 during reset, no response for the dropped op, new result 4 r1.
- With DIVSCHED_TIMEOUT_EN and divider model that never pulses div_ready -> resp_dbz=1, quotient 0xFFFF at WIDTH+8 cycles after div_start, timeout_err stays 1 until reset.
